// File: rtl/dircc_status_arbiter.sv
// Purpose: round-robin arbiter sharing one dircc status register Avalon-MM slave among NUM_REQ requesters.
// Latency: 1 cycle of arbitration, then a combinational pass-through to the slave; at most one read outstanding.
// Backpressure: non-granted requesters are always stalled; the granted one follows sts_waitrequest and is stalled while its read is outstanding.
// Optional feature: define DIRCC_STATUS_ARB_LOCK_EN to let req_lock keep the grant across completions.
module dircc_status_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address,
    input  logic [NUM_REQ-1:0]            req_read,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_writedata,
    input  logic [NUM_REQ-1:0]            req_lock,
    output logic [NUM_REQ-1:0]            req_waitrequest,
    output logic [DATA_WIDTH-1:0]         req_readdata,
    output logic [NUM_REQ-1:0]            req_readdatavalid,
    output logic [NUM_REQ-1:0]            grant,
    output logic [ADDR_WIDTH-1:0]         sts_address,
    output logic                          sts_read,
    output logic                          sts_write,
    output logic [DATA_WIDTH-1:0]         sts_writedata,
    input  logic                          sts_waitrequest,
    input  logic [DATA_WIDTH-1:0]         sts_readdata,
    input  logic                          sts_readdatavalid
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQ - 1);
    localparam logic [IDXW:0]   NREQ_W   = (IDXW + 1)'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;

    state_t                 state, state_nxt;
    logic [NUM_REQ-1:0]     grant_q;
    logic [IDXW-1:0]        grant_idx;
    logic [IDXW-1:0]        rr_ptr;

    logic [ADDR_WIDTH-1:0]  addr_a  [NUM_REQ];
    logic [DATA_WIDTH-1:0]  wdata_a [NUM_REQ];
    logic [NUM_REQ-1:0]     req_any;

    logic                   win_found;
    logic [IDXW-1:0]        win_idx;
    logic [IDXW:0]          cand_w;
    logic [NUM_REQ-1:0]     win_onehot;

    logic                   sel_rd, sel_wr;
    logic                   load_grant, clear_grant, adv_ptr, complete;

    assign req_any      = req_read | req_write;
    assign grant        = grant_q;
    assign req_readdata = sts_readdata;
    assign sel_rd       = req_read[grant_idx];
    assign sel_wr       = req_write[grant_idx];

    // Unpack the flat per-requester buses into indexable arrays
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            addr_a[i]  = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_a[i] = req_writedata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Round-robin search: first active requester at or after rr_ptr, wrapping
    always_comb begin
        win_found  = 1'b0;
        win_idx    = rr_ptr;
        cand_w     = '0;
        win_onehot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_w = {1'b0, rr_ptr} + (IDXW + 1)'(k);
            if (cand_w >= NREQ_W) begin
                cand_w = cand_w - NREQ_W;
            end
            if (!win_found && req_any[cand_w[IDXW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand_w[IDXW-1:0];
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            win_onehot[i] = (win_idx == IDXW'(i));
        end
    end

    // Next state and slave/requester outputs; everything idles to 0 / stalled
    always_comb begin
        state_nxt         = state;
        load_grant        = 1'b0;
        clear_grant       = 1'b0;
        adv_ptr           = 1'b0;
        complete          = 1'b0;
        sts_address       = '0;
        sts_read          = 1'b0;
        sts_write         = 1'b0;
        sts_writedata     = '0;
        req_waitrequest   = '1;
        req_readdatavalid = '0;

        case (state)
            IDLE: begin
                if (win_found) begin
                    load_grant = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                sts_address                = addr_a[grant_idx];
                sts_writedata              = wdata_a[grant_idx];
                sts_read                   = sel_rd;
                // a simultaneous read+write forwards only the read
                sts_write                  = sel_wr & ~sel_rd;
                req_waitrequest[grant_idx] = sts_waitrequest;
                if (!sel_rd && !sel_wr) begin
                    // requester withdrew before acceptance: nothing issued, pointer kept
                    state_nxt   = IDLE;
                    clear_grant = 1'b1;
                end else if (!sts_waitrequest) begin
                    if (sel_rd) begin
                        state_nxt = WAIT_RD;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            WAIT_RD: begin
                if (sts_readdatavalid) begin
                    req_readdatavalid = grant_q;
                    complete          = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (complete) begin
`ifdef DIRCC_STATUS_ARB_LOCK_EN
            if (req_lock[grant_idx]) begin
                // locked owner keeps the port and goes straight to its next access
                state_nxt = ISSUE;
            end else begin
                state_nxt   = IDLE;
                clear_grant = 1'b1;
                adv_ptr     = 1'b1;
            end
`else
            state_nxt   = IDLE;
            clear_grant = 1'b1;
            adv_ptr     = 1'b1;
`endif
        end
    end

`ifndef DIRCC_STATUS_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // State, grant and round-robin pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_q   <= '0;
            grant_idx <= '0;
            rr_ptr    <= '0;
        end else begin
            state <= state_nxt;
            if (load_grant) begin
                grant_q   <= win_onehot;
                grant_idx <= win_idx;
            end else if (clear_grant) begin
                grant_q <= '0;
            end
            if (adv_ptr) begin
                rr_ptr <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dircc_status_arbiter.sv
// Directed bench for dircc_status_arbiter: reset, single write, round robin,
// read stall, wait hold, abandon/read+write, lock and reset during a read.
module tb_dircc_status_arbiter;
    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*AW-1:0] req_address;
    logic [N-1:0]    req_read, req_write, req_lock;
    logic [N*DW-1:0] req_writedata;
    logic [N-1:0]    req_waitrequest, req_readdatavalid, grant;
    logic [DW-1:0]   req_readdata;
    logic [AW-1:0]   sts_address;
    logic            sts_read, sts_write, sts_waitrequest, sts_readdatavalid;
    logic [DW-1:0]   sts_writedata, sts_readdata;

    int nvec = 0;
    int nerr = 0;

    dircc_status_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req_address(req_address), .req_read(req_read), .req_write(req_write),
        .req_writedata(req_writedata), .req_lock(req_lock),
        .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid), .grant(grant),
        .sts_address(sts_address), .sts_read(sts_read), .sts_write(sts_write),
        .sts_writedata(sts_writedata), .sts_waitrequest(sts_waitrequest),
        .sts_readdata(sts_readdata), .sts_readdatavalid(sts_readdatavalid)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_all;
        req_address = '0; req_read = '0; req_write = '0; req_writedata = '0; req_lock = '0;
        sts_waitrequest = 1'b0; sts_readdata = '0; sts_readdatavalid = 1'b0;
    endtask

    task automatic set_req(input int i, input logic rd, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_read[i] = rd;
        req_write[i] = wr;
        req_address[i*AW +: AW] = a;
        req_writedata[i*DW +: DW] = d;
    endtask

    task automatic do_reset;
        clear_all;
        reset = 1'b1;
        step;
        step;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        clear_all;
        req_write = 4'b1111;
        sts_readdatavalid = 1'b1;
        reset = 1'b1;
        step;
        @(negedge clk);
        nvec++; if (grant !== 4'b0000) begin nerr++; $display("FAIL rst_grant got %b want 0000", grant); end
        nvec++; if (sts_read !== 1'b0 || sts_write !== 1'b0) begin nerr++; $display("FAIL rst_strobes got rd=%b wr=%b want 0 0", sts_read, sts_write); end
        nvec++; if (sts_address !== 4'h0 || sts_writedata !== 16'h0) begin nerr++; $display("FAIL rst_bus got a=%h d=%h want 0 0", sts_address, sts_writedata); end
        nvec++; if (req_waitrequest !== 4'b1111) begin nerr++; $display("FAIL rst_wait got %b want 1111", req_waitrequest); end
        nvec++; if (req_readdatavalid !== 4'b0000) begin nerr++; $display("FAIL rst_rdv got %b want 0000", req_readdatavalid); end
        clear_all;
        step;
        reset = 1'b0;
    endtask

    task automatic test_single_write;
        do_reset;
        set_req(0, 1'b0, 1'b1, 4'h0, 16'h1234);
        @(negedge clk);
        nvec++; if (grant !== 4'b0000 || sts_write !== 1'b0) begin nerr++; $display("FAIL sw_arb got g=%b wr=%b want 0000 0", grant, sts_write); end
        step;
        @(negedge clk);
        nvec++; if (grant !== 4'b0001) begin nerr++; $display("FAIL sw_grant got %b want 0001", grant); end
        nvec++; if (sts_write !== 1'b1 || sts_writedata !== 16'h1234 || sts_address !== 4'h0) begin nerr++; $display("FAIL sw_issue got wr=%b d=%h a=%h want 1 1234 0", sts_write, sts_writedata, sts_address); end
        nvec++; if (req_waitrequest !== 4'b1110) begin nerr++; $display("FAIL sw_wait got %b want 1110", req_waitrequest); end
        step;
        clear_all;
        @(negedge clk);
        nvec++; if (grant !== 4'b0000 || sts_write !== 1'b0) begin nerr++; $display("FAIL sw_done got g=%b wr=%b want 0000 0", grant, sts_write); end
    endtask

    task automatic test_round_robin;
        logic [3:0]  got_g [4];
        logic [15:0] got_d [4];
        logic [3:0]  acc, eg;
        int n = 0;
        do_reset;
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b1, 4'(4 + 2*i), 16'(16'hA000 + i));
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge clk);
            acc = req_write & ~req_waitrequest;
            if (sts_write && !sts_waitrequest) begin
                got_g[n] = grant;
                got_d[n] = sts_writedata;
                n++;
            end
            step;
            req_write = req_write & ~acc;
        end
        nvec++; if (n != 4) begin nerr++; $display("FAIL rr_count got %0d want 4", n); end
        for (int k = 0; k < n; k++) begin
            eg = 4'(1 << k);
            nvec++; if (got_g[k] !== eg || got_d[k] !== 16'(16'hA000 + k)) begin nerr++; $display("FAIL rr_order[%0d] got g=%b d=%h want %b %h", k, got_g[k], got_d[k], eg, 16'(16'hA000 + k)); end
        end
        set_req(0, 1'b0, 1'b1, 4'h0, 16'h0001);
        set_req(3, 1'b0, 1'b1, 4'h0, 16'h0003);
        step;
        @(negedge clk);
        nvec++; if (grant !== 4'b0001) begin nerr++; $display("FAIL rr_wrap got %b want 0001", grant); end
        step;
        clear_all;
        step;
    endtask

    task automatic test_read_stall;
        do_reset;
        set_req(1, 1'b0, 1'b1, 4'h0, 16'h1111);
        step;
        step;
        clear_all;
        set_req(1, 1'b1, 1'b0, 4'h0, 16'h0);
        set_req(2, 1'b1, 1'b0, 4'h2, 16'h0);
        @(negedge clk);
        nvec++; if (grant !== 4'b0000) begin nerr++; $display("FAIL rd_arb got %b want 0000", grant); end
        step;
        @(negedge clk);
        nvec++; if (grant !== 4'b0100 || sts_read !== 1'b1 || sts_address !== 4'h2) begin nerr++; $display("FAIL rd_issue got g=%b rd=%b a=%h want 0100 1 2", grant, sts_read, sts_address); end
        nvec++; if (req_waitrequest !== 4'b1011) begin nerr++; $display("FAIL rd_wait got %b want 1011", req_waitrequest); end
        step;
        req_read[2] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            nvec++; if (req_waitrequest !== 4'b1111 || req_readdatavalid !== 4'b0000 || sts_read !== 1'b0) begin nerr++; $display("FAIL rd_pend%0d got w=%b v=%b rd=%b want 1111 0000 0", c, req_waitrequest, req_readdatavalid, sts_read); end
            step;
        end
        sts_readdatavalid = 1'b1;
        sts_readdata = 16'hBEEF;
        @(negedge clk);
        nvec++; if (req_readdatavalid !== 4'b0100 || req_readdata !== 16'hBEEF) begin nerr++; $display("FAIL rd_data got v=%b d=%h want 0100 beef", req_readdatavalid, req_readdata); end
        step;
        sts_readdatavalid = 1'b0;
        @(negedge clk);
        nvec++; if (req_readdatavalid !== 4'b0000 || grant !== 4'b0000) begin nerr++; $display("FAIL rd_end got v=%b g=%b want 0000 0000", req_readdatavalid, grant); end
        step;
        sts_waitrequest = 1'b1;
        sts_readdatavalid = 1'b1;
        @(negedge clk);
        nvec++; if (grant !== 4'b0010 || sts_read !== 1'b1 || sts_address !== 4'h0) begin nerr++; $display("FAIL rd_second got g=%b rd=%b a=%h want 0010 1 0", grant, sts_read, sts_address); end
        nvec++; if (req_readdatavalid !== 4'b0000 || req_waitrequest !== 4'b1111) begin nerr++; $display("FAIL rd_ignore got v=%b w=%b want 0000 1111", req_readdatavalid, req_waitrequest); end
        step;
        sts_waitrequest = 1'b0;
        sts_readdatavalid = 1'b0;
        @(negedge clk);
        nvec++; if (req_waitrequest !== 4'b1101) begin nerr++; $display("FAIL rd_acc got %b want 1101", req_waitrequest); end
        step;
        req_read[1] = 1'b0;
        sts_readdatavalid = 1'b1;
        sts_readdata = 16'h5A5A;
        @(negedge clk);
        nvec++; if (req_readdatavalid !== 4'b0010 || req_readdata !== 16'h5A5A) begin nerr++; $display("FAIL rd_data2 got v=%b d=%h want 0010 5a5a", req_readdatavalid, req_readdata); end
        step;
        clear_all;
    endtask

    task automatic test_wait_hold;
        do_reset;
        sts_waitrequest = 1'b1;
        set_req(1, 1'b0, 1'b1, 4'h6, 16'h6666);
        set_req(3, 1'b0, 1'b1, 4'h8, 16'h8888);
        step;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            nvec++; if (grant !== 4'b0010 || sts_write !== 1'b1 || sts_address !== 4'h6 || sts_writedata !== 16'h6666 || req_waitrequest !== 4'b1111) begin
                nerr++; $display("FAIL hold%0d got g=%b wr=%b a=%h d=%h w=%b want 0010 1 6 6666 1111", c, grant, sts_write, sts_address, sts_writedata, req_waitrequest);
            end
            step;
        end
        sts_waitrequest = 1'b0;
        @(negedge clk);
        nvec++; if (req_waitrequest !== 4'b1101 || sts_write !== 1'b1) begin nerr++; $display("FAIL hold_rel got w=%b wr=%b want 1101 1", req_waitrequest, sts_write); end
        step;
        req_write[1] = 1'b0;
        @(negedge clk);
        nvec++; if (grant !== 4'b0000) begin nerr++; $display("FAIL hold_idle got %b want 0000", grant); end
        step;
        @(negedge clk);
        nvec++; if (grant !== 4'b1000 || sts_address !== 4'h8) begin nerr++; $display("FAIL hold_next got g=%b a=%h want 1000 8", grant, sts_address); end
        step;
        clear_all;
    endtask

    task automatic test_abandon_rw;
        do_reset;
        sts_waitrequest = 1'b1;
        set_req(2, 1'b0, 1'b1, 4'h4, 16'h4444);
        step;
        @(negedge clk);
        nvec++; if (grant !== 4'b0100 || sts_write !== 1'b1) begin nerr++; $display("FAIL ab_issue got g=%b wr=%b want 0100 1", grant, sts_write); end
        step;
        req_write[2] = 1'b0;
        @(negedge clk);
        nvec++; if (sts_write !== 1'b0 || sts_read !== 1'b0 || grant !== 4'b0100) begin nerr++; $display("FAIL ab_drop got wr=%b rd=%b g=%b want 0 0 0100", sts_write, sts_read, grant); end
        step;
        @(negedge clk);
        nvec++; if (grant !== 4'b0000) begin nerr++; $display("FAIL ab_idle got %b want 0000", grant); end
        sts_waitrequest = 1'b0;
        set_req(2, 1'b1, 1'b1, 4'h2, 16'h2222);
        set_req(3, 1'b0, 1'b1, 4'h8, 16'h3333);
        step;
        @(negedge clk);
        nvec++; if (grant !== 4'b0100) begin nerr++; $display("FAIL ab_ptr got %b want 0100", grant); end
        nvec++; if (sts_read !== 1'b1 || sts_write !== 1'b0 || sts_address !== 4'h2) begin nerr++; $display("FAIL rw_read got rd=%b wr=%b a=%h want 1 0 2", sts_read, sts_write, sts_address); end
        step;
        req_read[2] = 1'b0;
        req_write[2] = 1'b0;
        sts_readdatavalid = 1'b1;
        @(negedge clk);
        nvec++; if (req_readdatavalid !== 4'b0100) begin nerr++; $display("FAIL rw_rdv got %b want 0100", req_readdatavalid); end
        step;
        sts_readdatavalid = 1'b0;
        step;
        @(negedge clk);
        nvec++; if (grant !== 4'b1000) begin nerr++; $display("FAIL rw_next got %b want 1000", grant); end
        step;
        clear_all;
    endtask

    task automatic test_lock;
        logic [3:0] exp_g [5];
        logic [3:0] exp_a [5];
        int         exp_c [5];
        logic [3:0] got_g [5];
        logic [3:0] got_a [5];
        int         got_c [5];
        logic [3:0] acc;
        int n = 0;
        int w3 = 0;
`ifdef DIRCC_STATUS_ARB_LOCK_EN
        exp_g = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
        exp_a = '{4'h4, 4'h6, 4'h8, 4'hA, 4'h0};
        exp_c = '{0, 1, 2, 3, 5};
`else
        exp_g = '{4'b1000, 4'b0001, 4'b1000, 4'b1000, 4'b1000};
        exp_a = '{4'h4, 4'h0, 4'h6, 4'h8, 4'hA};
        exp_c = '{0, 2, 4, 6, 8};
`endif
        do_reset;
        set_req(3, 1'b0, 1'b1, 4'h4, 16'hC000);
        req_lock[3] = 1'b1;
        step;
        set_req(0, 1'b0, 1'b1, 4'h0, 16'h0F0F);
        for (int c = 0; c < 30 && n < 5; c++) begin
            @(negedge clk);
            if (sts_write && !sts_waitrequest) begin
                got_g[n] = grant;
                got_a[n] = sts_address;
                got_c[n] = c;
                n++;
            end
            acc = req_write & ~req_waitrequest;
            step;
            if (acc[0]) req_write[0] = 1'b0;
            if (acc[3]) begin
                w3++;
                if (w3 == 4) begin
                    req_write[3] = 1'b0;
                    req_lock[3] = 1'b0;
                end else begin
                    set_req(3, 1'b0, 1'b1, 4'(4 + 2*w3), 16'(16'hC000 + w3));
                    req_lock[3] = (w3 < 3);
                end
            end
        end
        nvec++; if (n != 5) begin nerr++; $display("FAIL lock_count got %0d want 5", n); end
        for (int k = 0; k < n; k++) begin
            nvec++; if (got_g[k] !== exp_g[k] || got_a[k] !== exp_a[k] || got_c[k] != exp_c[k]) begin
                nerr++; $display("FAIL lock_seq[%0d] got g=%b a=%h cyc=%0d want %b %h %0d", k, got_g[k], got_a[k], got_c[k], exp_g[k], exp_a[k], exp_c[k]);
            end
        end
        clear_all;
    endtask

    task automatic test_reset_in_wait_rd;
        do_reset;
        set_req(0, 1'b1, 1'b0, 4'h2, 16'h0);
        step;
        @(negedge clk);
        nvec++; if (grant !== 4'b0001 || sts_read !== 1'b1) begin nerr++; $display("FAIL rwr_issue got g=%b rd=%b want 0001 1", grant, sts_read); end
        step;
        req_read = '0;
        @(negedge clk);
        nvec++; if (req_waitrequest !== 4'b1111 || sts_read !== 1'b0) begin nerr++; $display("FAIL rwr_pend got w=%b rd=%b want 1111 0", req_waitrequest, sts_read); end
        reset = 1'b1;
        #1;
        nvec++; if (grant !== 4'b0000 || req_waitrequest !== 4'b1111) begin nerr++; $display("FAIL rwr_rst got g=%b w=%b want 0000 1111", grant, req_waitrequest); end
        step;
        reset = 1'b0;
        sts_readdatavalid = 1'b1;
        sts_readdata = 16'hDEAD;
        @(negedge clk);
        nvec++; if (req_readdatavalid !== 4'b0000 || grant !== 4'b0000) begin nerr++; $display("FAIL rwr_late got v=%b g=%b want 0000 0000", req_readdatavalid, grant); end
        step;
        sts_readdatavalid = 1'b0;
        set_req(1, 1'b0, 1'b1, 4'h4, 16'h7777);
        step;
        @(negedge clk);
        nvec++; if (grant !== 4'b0010 || sts_write !== 1'b1) begin nerr++; $display("FAIL rwr_idle got g=%b wr=%b want 0010 1", grant, sts_write); end
        step;
        clear_all;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        clear_all;
        reset = 1'b1;
        test_reset;
        test_single_write;
        test_round_robin;
        test_read_stall;
        test_wait_hold;
        test_abandon_rw;
        test_lock;
        test_reset_in_wait_rd;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
